// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access-size codes,
// FSM states and byte-enable generation.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Size code 2'b11 falls into the word case on purpose.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: byte_en = 4'b0001 << off;
      SZ_HALF: byte_en = 4'b0011 << off;
      default: byte_en = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_byte_lane_ram.sv
// DEPTH x 32 synchronous array with per-byte write enables and a registered,
// read-before-write output that only updates when en is high.
module dmem_byte_lane_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder on the req/addr_ok/data_ok handshake.
// Define DMEM_STALL_EN to add the WAIT state and LATENCY-cycle completion.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_req,
  input  logic                  data_wr,
  input  logic [1:0]            data_size,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  output logic                  data_addr_ok,
  output logic                  data_data_ok,
  output logic [DATA_WIDTH-1:0] data_rdata,
  output logic                  data_err
);

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("dmem_responder supports DATA_WIDTH=32 only");
  end
  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("dmem_responder LATENCY must be 1..15");
  end

  state_t                state;
  logic                  cap_wr;
  logic [1:0]            cap_size;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_wdata;

  logic                  accept;
  logic                  go_resp;
  logic                  have_q;
  logic                  err_q;
  logic                  a_wr;
  logic [1:0]            a_size;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  misal;
  logic [3:0]            be;
  logic [31:0]           wrep;
  logic [31:0]           ram_rd;

`ifdef DMEM_STALL_EN
  localparam logic [3:0] CNT_LOAD  = 4'((LATENCY > 1) ? (LATENCY - 2) : 0);
  localparam bit         SKIP_WAIT = (LATENCY <= 1);
  logic [3:0] cnt;
`endif

  // Reset low forces addr_ok off even while data_req is held high.
  assign accept       = rst && (state == IDLE) && data_req;
  assign data_addr_ok = accept;

`ifdef DMEM_STALL_EN
  assign go_resp = (accept && SKIP_WAIT) || ((state == WAIT) && (cnt == 4'd0));
`else
  assign go_resp = accept;
`endif

  // A single-cycle transaction reaches the array on its accepting edge,
  // before the capture registers hold it, so use the live inputs in IDLE.
  assign a_wr    = (state == IDLE) ? data_wr    : cap_wr;
  assign a_size  = (state == IDLE) ? data_size  : cap_size;
  assign a_addr  = (state == IDLE) ? data_addr  : cap_addr;
  assign a_wdata = (state == IDLE) ? data_wdata : cap_wdata;

  always_comb begin
    misal = 1'b0;
    if (a_size == SZ_HALF && a_addr[0])       misal = 1'b1;
    if (a_size[1] && (a_addr[1:0] != 2'b00))  misal = 1'b1;
    case (a_size)
      SZ_BYTE: wrep = {4{a_wdata[7:0]}};
      SZ_HALF: wrep = {2{a_wdata[15:0]}};
      default: wrep = a_wdata;
    endcase
    be = (a_wr && !misal) ? byte_en(a_size, a_addr[1:0]) : 4'b0000;
  end

  dmem_byte_lane_ram #(
    .DEPTH (DEPTH),
    .AW    (ADDR_WIDTH - 2)
  ) u_ram (
    .clk   (clk),
    .en    (go_resp),
    .we    (be),
    .addr  (a_addr[ADDR_WIDTH-1:2]),
    .wdata (wrep),
    .rdata (ram_rd)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      cap_wr    <= data_wr;
      cap_size  <= data_size;
      cap_addr  <= data_addr;
      cap_wdata <= data_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      data_data_ok <= 1'b0;
      have_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef DMEM_STALL_EN
      cnt          <= 4'd0;
`endif
    end else begin
      data_data_ok <= 1'b0;
      if (go_resp) begin
        state        <= RESP;
        data_data_ok <= 1'b1;
        have_q       <= 1'b1;
        err_q        <= misal;
      end else begin
        case (state)
`ifdef DMEM_STALL_EN
          IDLE: if (accept) begin
            state <= WAIT;
            cnt   <= CNT_LOAD;
          end
          WAIT: cnt <= cnt - 4'd1;
`else
          IDLE: state <= IDLE;
`endif
          RESP:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Misaligned accesses report zero data; the last response holds otherwise.
  assign data_rdata = (have_q && !err_q) ? ram_rd : '0;
  assign data_err   = err_q;

endmodule
